spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder: the far end of spi_master. One instance per slave address on the shared 3-bit ss select bus.
- Responds only when ss equals its SLAVE_ID. ss = 3'b111 means no slave is selected.
- Shifts MSB-first: captures the master's mosi bits and returns a preloaded word on miso.
- Presents each received word to local logic through a valid/ack interface.

Parameters:
- DATA_W, 8: frame width in bits, at least 2.
- SLAVE_ID, 3'b010: ss value that selects this slave.
- DEFAULT_TX, 8'hFF: word returned when no TX word is buffered (DATA_W bits).

Ports:
- sclk  in  1: serial clock; the only clock. All flops use its rising edge.
- reset  in  1: asynchronous, active-low reset.
- ss  in  3: slave select address.
- mosi  in  1: serial data from master.
- miso  out  1: serial data to master. Equals shift_reg[DATA_W-1] when miso_oe = 1, else 0.
- miso_oe  out  1: 1 while this slave owns miso.
- tx_data  in  DATA_W: word to return in the next frame.
- tx_load  in  1: write strobe for tx_data.
- tx_ready  out  1: TX buffer empty.
- rx_data  out  DATA_W: last received word.
- rx_valid  out  1: rx_data unread.
- rx_ack  in  1: local logic has consumed rx_data.
- busy  out  1: frame in progress.
- overrun  out  1: sticky; an unread word was overwritten.

Behaviour:
- Reset (reset = 0, asynchronous): applies immediately, including mid-frame. Reset values:
  - state IDLE, bit_cnt 0, shift_reg 0
  - miso 0, miso_oe 0, busy 0
  - rx_data 0, rx_valid 0, overrun 0
  - tx_ready 1, TX buffer 0
- sel = (ss == SLAVE_ID).
- TX buffer:
  - tx_load with tx_ready = 1 captures tx_data; tx_ready goes 0 on the next edge.
  - tx_load with tx_ready = 0 is ignored.
- States are IDLE and SHIFT.
- IDLE, sel = 1 (load edge):
  - shift_reg <= TX buffer if tx_ready = 0, else DEFAULT_TX.
  - tx_ready <= 1, bit_cnt <= 0, go to SHIFT.
  - miso_oe and busy go 1 after this edge; miso then shows the TX MSB.
- Load edge with tx_load and an empty buffer: the frame sends DEFAULT_TX; the new word is kept for the next frame and tx_ready goes 0.
- SHIFT, sel = 1 (one data edge per bit, DATA_W edges total):
  - shift_reg <= {shift_reg[DATA_W-2:0], mosi}, bit_cnt increments.
  - The master samples miso at data edge k and sees TX bit DATA_W-1-k.
  - The master must present mosi bit DATA_W-1-k before data edge k.
  - Total frame = 1 load edge + DATA_W data edges.
- Last data edge (bit_cnt = DATA_W-1):
  - rx_data <= {shift_reg[DATA_W-2:0], mosi}, rx_valid <= 1.
  - If rx_valid was 1 and rx_ack = 0 on that edge, overrun <= 1.
  - State returns to IDLE; miso_oe and busy go 0.
  - If sel is still 1, the next edge is the load edge of a new frame. There is one dead cycle between back-to-back frames.
- rx_valid clears on an edge with rx_ack = 1 and no completing frame. If rx_ack and a completion coincide, new data is stored, rx_valid stays 1, and no overrun is flagged.
- Deselect in SHIFT (sel = 0):
  - Abort: go to IDLE, bit_cnt 0, miso_oe 0.
  - No rx_valid is generated. The consumed TX word is discarded.
- overrun clears only on reset.
- ss changing to another slave's ID counts as deselect.

Test Plan:
- Reset, ss = 111, no activity -> miso = 0, miso_oe = 0, tx_ready = 1, rx_valid = 0 throughout. Assert reset mid-run -> all outputs return to reset values immediately.
- tx_load 8'hA5, ss = 010, master sends 8'h3C over 8 data edges -> miso sequence 1,0,1,0,0,1,0,1. rx_data = 8'h3C and rx_valid = 1 after the last edge. tx_ready = 1 after the load edge.
- No tx_load, ss = 010, master sends 8'h81 -> miso returns 8'hFF, rx_data = 8'h81.
- Two back-to-back frames (8'h11 then 8'h22) with no rx_ack -> rx_data = 8'h22, overrun = 1. Repeat with rx_ack after frame 1 -> overrun stays 0.
- Deselect (ss = 111) after 4 data edges -> miso_oe = 0, rx_valid unchanged. Next full frame of 8'h5A -> rx_data = 8'h5A.
- ss = 000 (different ID) with mosi toggling -> miso_oe stays 0, no state change. tx_load while tx_ready = 0 -> word ignored, original word transmitted.

Source files
------------

// File: rtl/spi_slave.sv
// SPI responder for one address on a shared 3-bit select bus.
// Mode-0 style: MSB-first, all state advances on the rising edge of sclk.
module spi_slave #(
  parameter int                DATA_W     = 8,
  parameter logic [2:0]        SLAVE_ID   = 3'b010,
  parameter logic [DATA_W-1:0] DEFAULT_TX = {DATA_W{1'b1}}
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic [2:0]        ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0]   shift_r, shift_nxt_s;
  logic [DATA_W-1:0]   txbuf_r, txbuf_nxt_s;
  logic                tx_ready_r, tx_ready_nxt_s;
  logic [DATA_W-1:0]   rx_data_r, rx_data_nxt_s;
  logic                rx_valid_r, rx_valid_nxt_s;
  logic                overrun_r, overrun_nxt_s;
  logic                oe_r, busy_r, oe_nxt_s;
  logic                sel_s, load_edge_s, tx_take_s, done_s;

  assign sel_s       = (ss == SLAVE_ID);
  assign load_edge_s = (state_r == IDLE) && sel_s;
  assign tx_take_s   = tx_load && tx_ready_r;

  // Next-state, shift datapath, TX buffer and RX handshake
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    shift_nxt_s    = shift_r;
    rx_data_nxt_s  = rx_data_r;
    rx_valid_nxt_s = rx_valid_r;
    overrun_nxt_s  = overrun_r;
    done_s         = 1'b0;

    case (state_r)
      IDLE: begin
        if (sel_s) begin
          shift_nxt_s = tx_ready_r ? DEFAULT_TX : txbuf_r;
          cnt_nxt_s   = '0;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (!sel_s) begin
          // abort: partial word and consumed TX word are dropped
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          shift_nxt_s = {shift_r[DATA_W-2:0], mosi};
          if (cnt_r == LAST_CNT) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + 1'b1;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase

    // a load edge frees the buffer; a same-edge tx_load refills it for the next frame
    txbuf_nxt_s    = tx_take_s ? tx_data : txbuf_r;
    tx_ready_nxt_s = tx_take_s ? 1'b0 : (load_edge_s ? 1'b1 : tx_ready_r);

    if (done_s) begin
      rx_data_nxt_s  = shift_nxt_s;
      rx_valid_nxt_s = 1'b1;
      overrun_nxt_s  = overrun_r | (rx_valid_r & ~rx_ack);
    end else if (rx_ack) begin
      rx_valid_nxt_s = 1'b0;
    end else begin
      rx_valid_nxt_s = rx_valid_r;
    end

    oe_nxt_s = (state_nxt_s == SHIFT);
  end

  // State and datapath registers
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      shift_r    <= '0;
      txbuf_r    <= '0;
      tx_ready_r <= 1'b1;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      txbuf_r    <= txbuf_nxt_s;
      tx_ready_r <= tx_ready_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      rx_valid_r <= rx_valid_nxt_s;
      overrun_r  <= overrun_nxt_s;
      oe_r       <= oe_nxt_s;
      busy_r     <= oe_nxt_s;
    end
  end

  assign miso     = oe_r & shift_r[DATA_W-1];
  assign miso_oe  = oe_r;
  assign busy     = busy_r;
  assign tx_ready = tx_ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: inputs change after the falling edge,
// outputs are checked at the falling edge following each rising edge.
module tb_spi_slave;

  localparam logic [2:0] ID   = 3'b010;
  localparam logic [2:0] NONE = 3'b111;

  logic       sclk = 1'b0;
  logic       reset;
  logic [2:0] ss;
  logic       mosi;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_ack, busy, overrun, tx_load;
  logic [7:0] tx_data, rx_data;

  int n_vec = 0;
  int n_err = 0;

  spi_slave #(.DATA_W(8), .SLAVE_ID(3'b010), .DEFAULT_TX(8'hFF)) dut (
    .sclk(sclk), .reset(reset), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .overrun(overrun)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic load_tx(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    step();
    tx_load = 1'b0;
  endtask

  // load edge plus nbits data edges; miso checked before each data edge
  task automatic frame(input logic [7:0] mo, input logic [7:0] exp_miso, input int nbits,
                       input bit keep_sel, input bit ack_last);
    ss = ID;
    step();
    rx_ack = 1'b0;
    check("oe_after_load", miso_oe, 8'd1);
    check("busy_after_load", busy, 8'd1);
    check("txrdy_after_load", tx_ready, 8'd1);
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[7-k];
      if (ack_last && k == 7) rx_ack = 1'b1;
      check($sformatf("miso_bit%0d", k), miso, exp_miso[7-k]);
      step();
      rx_ack = 1'b0;
    end
    if (!keep_sel) ss = NONE;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_oe"}, miso_oe, 8'd0);
    check({tag, "_busy"}, busy, 8'd0);
    check({tag, "_miso"}, miso, 8'd0);
  endtask

  initial begin
    reset = 1'b0; ss = NONE; mosi = 1'b0; rx_ack = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    step();
    step();
    reset = 1'b1;

    // idle with no slave selected
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      step();
      check_idle("idle");
      check("idle_txrdy", tx_ready, 8'd1);
      check("idle_rxv", rx_valid, 8'd0);
    end

    // preloaded word A5, receive 3C
    load_tx(8'hA5);
    check("txrdy_after_load_tx", tx_ready, 8'd0);
    frame(8'h3C, 8'hA5, 8, 1'b0, 1'b0);
    check_idle("f1_end");
    check("f1_rxdata", rx_data, 8'h3C);
    check("f1_rxv", rx_valid, 8'd1);
    rx_ack = 1'b1; step(); rx_ack = 1'b0;
    check("ack_clears_rxv", rx_valid, 8'd0);

    // nothing buffered -> default word
    frame(8'h81, 8'hFF, 8, 1'b0, 1'b0);
    check("f2_rxdata", rx_data, 8'h81);
    check("f2_rxv", rx_valid, 8'd1);
    rx_ack = 1'b1; step(); rx_ack = 1'b0;

    // back-to-back, no ack -> overrun
    frame(8'h11, 8'hFF, 8, 1'b1, 1'b0);
    check("b2b_mid_rxdata", rx_data, 8'h11);
    frame(8'h22, 8'hFF, 8, 1'b0, 1'b0);
    check("b2b_rxdata", rx_data, 8'h22);
    check("b2b_overrun", overrun, 8'd1);
    step();
    check("overrun_sticky", overrun, 8'd1);

    // async reset mid-frame
    load_tx(8'h5C);
    ss = ID; step();
    for (int k = 0; k < 3; k++) begin mosi = 1'b1; step(); end
    #2 reset = 1'b0;
    #1;
    check_idle("rst");
    check("rst_txrdy", tx_ready, 8'd1);
    check("rst_rxv", rx_valid, 8'd0);
    check("rst_rxdata", rx_data, 8'h00);
    check("rst_overrun", overrun, 8'd0);
    ss = NONE;
    @(negedge sclk);
    reset = 1'b1;
    step();
    check("post_rst_oe", miso_oe, 8'd0);

    // back-to-back with ack during the second load edge -> no overrun
    frame(8'h11, 8'hFF, 8, 1'b1, 1'b0);
    rx_ack = 1'b1;
    frame(8'h22, 8'hFF, 8, 1'b1, 1'b0);
    check("b2b_ack_rxdata", rx_data, 8'h22);
    check("b2b_ack_overrun", overrun, 8'd0);
    // ack coinciding with completion: new data kept, still valid, no overrun
    frame(8'h33, 8'hFF, 8, 1'b0, 1'b1);
    check("coinc_rxdata", rx_data, 8'h33);
    check("coinc_rxv", rx_valid, 8'd1);
    check("coinc_overrun", overrun, 8'd0);
    rx_ack = 1'b1; step(); rx_ack = 1'b0;

    // abort after 4 data edges; consumed word 96 is discarded
    load_tx(8'h96);
    frame(8'hF0, 8'h96, 4, 1'b0, 1'b0);
    step();
    check_idle("abort");
    check("abort_rxv", rx_valid, 8'd0);
    check("abort_txrdy", tx_ready, 8'd1);
    frame(8'h5A, 8'hFF, 8, 1'b0, 1'b0);
    check("after_abort_rxdata", rx_data, 8'h5A);
    check("after_abort_rxv", rx_valid, 8'd1);

    // other slave's address: nothing moves
    ss = 3'b000;
    for (int i = 0; i < 4; i++) begin
      mosi = ~mosi;
      step();
      check_idle("other_id");
      check("other_id_rxdata", rx_data, 8'h5A);
    end
    ss = NONE;
    rx_ack = 1'b1; step(); rx_ack = 1'b0;

    // second tx_load while full is ignored
    load_tx(8'hC3);
    load_tx(8'h3C);
    check("ignored_load_txrdy", tx_ready, 8'd0);
    frame(8'h00, 8'hC3, 8, 1'b0, 1'b0);
    check("c3_rxdata", rx_data, 8'h00);
    check("c3_rxv", rx_valid, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
